// File: rtl/tinyalu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_pkg
// Description : Shared types for the tinyalu instruction sequencer. Holds the
//               instruction word layout, the ALU operation codes, the
//               sequencer state encoding and op-legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100
    } operation_t;

    // The op field stays raw so that codes 101..111 can be carried and reported.
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] A;
        logic [7:0] B;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

    // Legal and not a no_op, i.e. something the ALU actually has to execute.
    function automatic logic is_alu_op(input logic [2:0] op);
        return is_legal_op(op) && (op != no_op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_instr_sequencer_if
// Description : Bundle of the sequencer's three channels.
//               Instruction in : instr_valid, instr, instr_ready
//               ALU pins       : alu_start, alu_op, alu_A, alu_B,
//                                alu_done, alu_result
//               Response out   : res_valid, res_data, res_op, res_err,
//                                res_ready
//               Status         : busy
//               slave  = sequencer side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_instr_sequencer_if;
    import tinyalu_pkg::*;

    logic         instr_valid;
    instruction_t instr;
    logic         instr_ready;

    logic         alu_start;
    logic [2:0]   alu_op;
    logic [7:0]   alu_A;
    logic [7:0]   alu_B;
    logic         alu_done;
    logic [15:0]  alu_result;

    logic         res_valid;
    logic [15:0]  res_data;
    logic [2:0]   res_op;
    logic         res_err;
    logic         res_ready;

    logic         busy;

    modport slave (
        input  instr_valid, instr, alu_done, alu_result, res_ready,
        output instr_ready, alu_start, alu_op, alu_A, alu_B,
               res_valid, res_data, res_op, res_err, busy
    );

    modport master (
        output instr_valid, instr, alu_done, alu_result, res_ready,
        input  instr_ready, alu_start, alu_op, alu_A, alu_B,
               res_valid, res_data, res_op, res_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Generic synchronous FIFO, DEPTH entries (power of 2) of type T.
//               Ports: clk, reset_n (async, active low), i_push/i_data,
//               i_pop/o_data (head, valid while !o_empty), o_count,
//               o_full, o_empty. Push when full and pop when empty are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   i_push,
    input  wire T                       i_data,
    input  wire logic                   i_pop,
    output T                            o_data,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]   count_q,  count_d;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (count_q == (c_AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_instr_sequencer
// Description : Buffers instructions in a FIFO, issues them one at a time to
//               the tinyalu core (start held until done, start low for at
//               least one cycle between operations), handles no_op / illegal
//               ops locally, aborts after TIMEOUT ISSUE cycles without done,
//               and returns each result over a valid/ready response port.
//               Ports: clk, reset_n (async, active low), bus (slave modport:
//               instruction, ALU and response channels plus busy).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_instr_sequencer
    import tinyalu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    alu_instr_sequencer_if.slave bus
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);
    // Counter value seen on the last allowed ISSUE cycle.
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    seq_state_t      state_q,     state_d;
    logic            alu_start_q, alu_start_d;
    logic [2:0]      alu_op_q,    alu_op_d;
    logic [7:0]      alu_a_q,     alu_a_d;
    logic [7:0]      alu_b_q,     alu_b_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q,  res_data_d;
    logic [2:0]      res_op_q,    res_op_d;
    logic            res_err_q,   res_err_d;
    logic [c_TW-1:0] tmo_q,       tmo_d;

    instruction_t    w_head;
    logic [c_CW-1:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;

    instr_fifo #(
        .DEPTH (DEPTH),
        .T     (instruction_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (bus.instr_valid),
        .i_data  (bus.instr),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        alu_start_d = alu_start_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        tmo_d       = tmo_q;
        w_pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_count != '0) begin
                    w_pop    = 1'b1;
                    res_op_d = w_head.op;
                    if (is_alu_op(w_head.op)) begin
                        alu_op_d    = w_head.op;
                        alu_a_d     = w_head.A;
                        alu_b_d     = w_head.B;
                        alu_start_d = 1'b1;
                        tmo_d       = '0;
                        state_d     = ISSUE;
                    end else begin
                        // Answered locally; the ALU never sees these.
                        res_data_d  = '0;
                        res_err_d   = !is_legal_op(w_head.op);
                        res_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: begin
                // done is tested first so it wins a tie with the timeout.
                if (bus.alu_done) begin
                    res_data_d  = bus.alu_result;
                    res_err_d   = 1'b0;
                    alu_start_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_q == c_TMO_LAST) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    alu_start_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                // Leaving through IDLE gives start its mandatory low cycle.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                alu_start_d = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_start_q <= alu_start_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.instr_ready = !w_full;
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_A       = alu_a_q;
    assign bus.alu_B       = alu_b_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_op      = res_op_q;
    assign bus.res_err     = res_err_q;
    assign bus.busy        = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_instr_sequencer
// Description : Self-checking bench for alu_instr_sequencer. Contains an ALU
//               model with per-instruction done latency, a response
//               scoreboard fed from accepted instructions, directed scenarios
//               and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_instr_sequencer;
    import tinyalu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    alu_instr_sequencer_if bus();

    alu_instr_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cur_lat = 1;
    int   rdy_mode = 1;    // 0: hold low, 1: hold high, 2: random
    int   exp_issue = 0;
    int   n_rises = 0;
    exp_t exp_q[$];
    int   lat_q[$];        // done latency per ALU op, 0 = never

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return {8'h00, a} + {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // How many cycles start must stay high for a given ALU latency.
    function automatic int exp_len(input int lat);
        return (lat == 0 || lat > TIMEOUT) ? TIMEOUT : lat;
    endfunction

    // ALU model plus start protocol checks.
    initial begin : alu_model
        int         st;
        int         lat;
        int         last_rise;
        bit         prev;
        logic [2:0] op_c;
        logic [7:0] a_c;
        logic [7:0] b_c;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        st = 0; lat = 1; prev = 0; last_rise = -100;
        op_c = '0; a_c = '0; b_c = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                st = 0; prev = 0; last_rise = -100;
                bus.alu_done = 1'b0;
            end else if (bus.alu_start) begin
                if (!prev) begin
                    n_rises++;
                    chk("start_spacing_ge3", 32'(cyc - last_rise >= 3), 1);
                    last_rise = cyc;
                    if (lat_q.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                        lat = 1;
                    end else begin
                        lat = lat_q.pop_front();
                    end
                    op_c = bus.alu_op; a_c = bus.alu_A; b_c = bus.alu_B;
                    st = 0;
                end else begin
                    chk("operands_stable", {bus.alu_op, bus.alu_A, bus.alu_B}, {op_c, a_c, b_c});
                end
                st++;
                if (lat != 0 && st == lat) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = ref_alu(op_c, a_c, b_c);
                end else begin
                    bus.alu_done = 1'b0;
                end
                prev = 1;
            end else begin
                if (prev) chk("start_len", st, exp_len(lat));
                prev = 0; st = 0;
                bus.alu_done = 1'b0;
            end
        end
    end

    // Response-ready driver.
    initial begin : rdy_drv
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.res_ready = 1'b0;
                1:       bus.res_ready = 1'b1;
                default: bus.res_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference model on accepted instructions, scoreboard on responses.
    initial begin : monitor
        exp_t       e;
        exp_t       held;
        bit         stall;
        logic [2:0] o;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 0;
            end else begin
                if (bus.instr_valid && bus.instr_ready) begin
                    o = bus.instr.op;
                    e.op = o;
                    if (o == 3'd0) begin
                        e.data = 16'h0; e.err = 1'b0;
                    end else if (o > 3'd4) begin
                        e.data = 16'h0; e.err = 1'b1;
                    end else begin
                        exp_issue++;
                        lat_q.push_back(cur_lat);
                        if (cur_lat == 0 || cur_lat > TIMEOUT) begin
                            e.data = 16'h0; e.err = 1'b1;
                        end else begin
                            e.data = ref_alu(o, bus.instr.A, bus.instr.B); e.err = 1'b0;
                        end
                    end
                    exp_q.push_back(e);
                end
                if (bus.res_valid) begin
                    chk("start_low_in_resp", bus.alu_start, 0);
                    if (stall) begin
                        chk("hold_data", bus.res_data, held.data);
                        chk("hold_op",   bus.res_op,   held.op);
                        chk("hold_err",  bus.res_err,  held.err);
                    end
                    if (bus.res_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_resp", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("res_data", bus.res_data, e.data);
                            chk("res_op",   bus.res_op,   e.op);
                            chk("res_err",  bus.res_err,  e.err);
                        end
                        stall = 0;
                    end else begin
                        stall = 1;
                        held.data = bus.res_data; held.op = bus.res_op; held.err = bus.res_err;
                    end
                end
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input int max_wait, output bit acc);
        bus.instr_valid = 1'b1;
        bus.instr       = '{op: op, A: a, B: b};
        cur_lat         = lat;
        acc             = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            acc = bus.instr_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_time", 32'(k < 3000), 1);
        chk("issue_count", n_rises, exp_issue);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_start"}, bus.alu_start, 0);
        chk({tag, "_alu_op"},    bus.alu_op,    0);
        chk({tag, "_alu_A"},     bus.alu_A,     0);
        chk({tag, "_alu_B"},     bus.alu_B,     0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"},  bus.res_data,  0);
        chk({tag, "_res_op"},    bus.res_op,    0);
        chk({tag, "_res_err"},   bus.res_err,   0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_instr_rdy"}, bus.instr_ready, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit         acc;
        int         n_acc;
        int         r;
        int         lat;
        logic [2:0] op;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        reset_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Add with one-cycle done.
        push(3'b001, 8'h12, 8'h34, 1, 20, acc);
        chk("add_accept", acc, 1);
        drain();

        // Mul with three-cycle done followed directly by an add.
        push(3'b100, 8'hFF, 8'hFF, 3, 20, acc);
        push(3'b001, 8'h05, 8'h06, 2, 20, acc);
        push(3'b010, 8'hF0, 8'h3C, 1, 20, acc);
        push(3'b011, 8'hF0, 8'h3C, 4, 20, acc);
        drain();

        // No-op and illegal never reach the ALU.
        push(3'b000, 8'hAA, 8'h55, 1, 20, acc);
        push(3'b111, 8'hAA, 8'h55, 1, 20, acc);
        push(3'b101, 8'h01, 8'h02, 1, 20, acc);
        drain();

        // Timeout, recovery, done on the final allowed cycle, done one too late.
        push(3'b001, 8'h01, 8'h02, 0, 20, acc);
        push(3'b100, 8'h03, 8'h04, 1, 40, acc);
        push(3'b001, 8'h09, 8'h09, TIMEOUT, 40, acc);
        push(3'b010, 8'h0F, 8'h0F, TIMEOUT + 1, 40, acc);
        drain();

        // Back-pressure: one op parked in RESP plus a full FIFO.
        rdy_mode = 0;
        @(posedge clk); #1;
        n_acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(3'b001, 8'(i), 8'(16 + i), 1, 8, acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, DEPTH + 1);
        @(negedge clk);
        chk("bp_instr_ready_low", bus.instr_ready, 0);
        chk("bp_res_valid", bus.res_valid, 1);
        rdy_mode = 1;
        drain();

        // Asynchronous reset in the middle of a mul.
        push(3'b100, 8'hFF, 8'hFF, 3, 20, acc);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.alu_start) break;
        end
        chk("mul_started", bus.alu_start, 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        push(3'b001, 8'h01, 8'h01, 1, 20, acc);
        drain();

        // Randomized traffic with random response back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 15);
            if (r == 0)      lat = 0;
            else if (r == 1) lat = TIMEOUT;
            else if (r == 2) lat = TIMEOUT + 1;
            else             lat = $urandom_range(1, 5);
            push(op, 8'($urandom), 8'($urandom), lat, 300, acc);
            chk("rand_accept", acc, 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rdy_mode = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Instruction sequencer between the testbench instruction source and the tinyalu core. It accepts `instruction_t` words over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on the ALU's `start`/`op`/`A`/`B` pins, waits for `done`, and returns each result over a valid/ready response port. It also enforces the ALU protocol: `start` is held until `done`, and `start` goes low for at least one cycle between operations. No-op and illegal instructions are handled internally, and a done-timeout is enforced.

## Interface
Parameters:
- `DEPTH`, 4: instruction FIFO depth. Must be a power of 2, ≥2.
- `TIMEOUT`, 15: maximum number of ISSUE cycles without `alu_done` before the operation is aborted.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: upstream instruction valid.
- `instr` in `$bits(instruction_t)` (19): fields `{op[2:0], A[7:0], B[7:0]}`.
- `instr_ready` out 1: FIFO can accept an instruction.
- `alu_start` out 1: ALU start.
- `alu_op` out 3: ALU operation code.
- `alu_A` out 8: ALU operand A.
- `alu_B` out 8: ALU operand B.
- `alu_done` in 1: ALU completion.
- `alu_result` in 16: ALU result.
- `res_valid` out 1: response valid.
- `res_data` out 16: response result.
- `res_op` out 3: op of the completed instruction.
- `res_err` out 1: illegal op or timeout.
- `res_ready` in 1: downstream accepts the response.
- `busy` out 1: FSM is not IDLE or the FIFO is non-empty.

## Operation
- Op encoding: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. Codes 101–111 are illegal.
- FIFO:
  - A push occurs on `instr_valid && instr_ready`.
  - `instr_ready = (count < DEPTH)` and is registered-count based. A pop in the same cycle does not raise `instr_ready`.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
  - A push when full is ignored. Data is returned in FIFO order.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE with count>0: pop the head.
    - For add/and/xor/mul: latch op/A/B into output registers, set `alu_start=1`, go to ISSUE.
    - For no_op: set `res_data=0`, `res_err=0`, go to RESP. `alu_start` is not asserted.
    - For an illegal op: set `res_data=0`, `res_err=1`, go to RESP. `alu_start` is not asserted.
  - ISSUE: hold `alu_start` and the operands stable, and increment the timeout counter each cycle.
    - On `alu_done=1` at a rising edge: capture `alu_result` into `res_data`, set `res_err=0`, `alu_start←0`, go to RESP.
    - If the counter reaches TIMEOUT first: `res_data←0`, `res_err←1`, `alu_start←0`, go to RESP.
    - If `alu_done` and the timeout occur on the same edge, `done` wins.
  - RESP: `res_valid=1`. `res_data`, `res_op` and `res_err` are held stable until `res_ready`. On `res_valid && res_ready`, go to IDLE. `alu_start` is always 0 here, which guarantees the low gap of at least one cycle.
- `alu_A`/`alu_B`/`alu_op` keep their last issued values outside ISSUE. Only `alu_start` qualifies them.

## Timing
- Reset values of all outputs are 0: `alu_start`, `alu_op`, `alu_A`, `alu_B`, `res_valid`, `res_data`, `res_op`, `res_err`, `busy`.
- `instr_ready` is 1 after reset, since the FIFO is empty.
- Reset is asynchronous. Asserting it mid-ISSUE drops `alu_start` immediately, empties the FIFO, clears the timeout counter and returns the FSM to IDLE. No response is produced for lost instructions.
- Latency, pushed into an empty FIFO at edge t0 with FSM IDLE:
  - pop and `alu_start=1` from edge t1;
  - `res_valid` from the edge that samples `alu_done=1`;
  - no_op/illegal: `res_valid` from edge t1.
- Minimum spacing between successive `alu_start` rises is 3 cycles (ISSUE ≥1 cycle, RESP ≥1 cycle, IDLE 1 cycle).
- Back-pressure: while in RESP with `res_ready=0`, the FIFO still accepts pushes until count reaches DEPTH.

## Structure
- `tinyalu_pkg` holds:
  - `instruction_t` (packed struct);
  - `operation_t` enum (no_op..mul);
  - the FSM state enum `seq_state_t`;
  - a function `is_legal_op()`.
- Sub-module `instr_fifo`: parameterised DEPTH and data type. It provides push/pop/count/full/empty and is reusable by the result path later.
- The top level contains the FSM, operand registers and timeout counter only.

## Test plan
- Add: push {001, 8'h12, 8'h34}, ALU model asserts done 1 cycle after start → `alu_start` high with op 001, then `res_valid` with `res_data=16'h0046`, `res_op=001`, `res_err=0`.
- Mul: push {100, 8'hFF, 8'hFF}, ALU model gives a 3-cycle done → `alu_start` held 3+ cycles, `res_data=16'hFE01`, and `alu_start` low ≥1 cycle before the next op.
- Back-pressure: hold `res_ready=0` and push DEPTH+2 adds → exactly DEPTH+1 are accepted and `instr_ready` goes low. After releasing `res_ready`, all DEPTH+1 results come out in push order.
- No-op and illegal: push {000,..} then {111,..} → `alu_start` never rises. Responses are `res_data=0` with `res_err=0`, then `res_err=1`.
- Timeout: ALU model never asserts done → after TIMEOUT (15) ISSUE cycles `alu_start` drops, `res_err=1`, `res_data=0`, and the next queued instruction proceeds normally.
- Reset mid-mul: pull `reset_n` low 1 cycle after start → all outputs 0 asynchronously, `instr_ready=1`. A following add of 1+1 returns 16'h0002.
